// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encodings, opcodes,
// datapath select constants, the control-word struct and the DECODE dispatch function.
package mc_ctrl_pkg;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MADDR  = 4'd2,
        ST_MRD    = 4'd3,
        ST_MWB    = 4'd4,
        ST_MWR    = 4'd5,
        ST_REXE   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BEQ    = 4'd8,
        ST_JMP    = 4'd9,
        ST_IEXE   = 4'd10,
        ST_IWB    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Successor of DECODE; unsupported opcodes fall back to FETCH.
    function automatic state_e decode_next(input logic [5:0] op);
        case (op)
            OP_RTYPE:                         return ST_REXE;
            OP_LW, OP_SW:                     return ST_MADDR;
            OP_BEQ:                           return ST_BEQ;
            OP_J:                             return ST_JMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return ST_IEXE;
            default:                          return ST_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure combinational state -> control-word decode (Moore part of the control FSM).
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            ST_MWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_REXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            ST_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_IEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ITYPE;
            end
            ST_IWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and strobe gating.
// Optional build macro MC_CTRL_MEM_WAIT_EN stalls FETCH/MRD/MWR until mem_ready.
module mc_control
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_e state;
    ctrl_t  ctrl;
    logic   mem_go;
    logic   fetch_ok;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_go   = mem_ready;
    // FETCH keeps reading across the wait but only commits PC/IR on the completing cycle.
    assign fetch_ok = (state != ST_FETCH) || mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go   = 1'b1;
    assign fetch_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH:  if (mem_go) state <= ST_DECODE;
                ST_DECODE: state <= decode_next(opcode);
                ST_MADDR:  state <= (opcode == OP_LW) ? ST_MRD : ST_MWR;
                ST_MRD:    if (mem_go) state <= ST_MWB;
                ST_MWB:    state <= ST_FETCH;
                ST_MWR:    if (mem_go) state <= ST_FETCH;
                ST_REXE:   state <= ST_RWB;
                ST_RWB:    state <= ST_FETCH;
                ST_BEQ:    state <= ST_FETCH;
                ST_JMP:    state <= ST_FETCH;
                ST_IEXE:   state <= ST_IWB;
                ST_IWB:    state <= ST_FETCH;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    mc_ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    // Strobes are forced low while reset is held; mux selects pass straight through.
    assign PCWrite     = !rst && ctrl.pc_write && fetch_ok;
    assign IRWrite     = !rst && ctrl.ir_write && fetch_ok;
    assign PCWriteCond = !rst && ctrl.pc_write_cond;
    assign MemRead     = !rst && ctrl.mem_read;
    assign MemWrite    = !rst && ctrl.mem_write;
    assign RegWrite    = !rst && ctrl.reg_write;
    assign illegal_op  = !rst && (state == ST_DECODE) && (decode_next(opcode) == ST_FETCH);

    assign PCSource  = ctrl.pc_source;
    assign IorD      = ctrl.iord;
    assign RegDst    = ctrl.reg_dst;
    assign MemtoReg  = ctrl.mem_to_reg;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign state_dbg = STATE_W'(state);

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control against an instruction-level reference model.
module tb_mc_control;

`ifdef MC_CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    mc_control #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, mrd, mwr, irw, rw, ill;
        logic [1:0] pcs;
        logic       iord, rdst, m2r, asa;
        logic [1:0] asb, aop;
    } ob_t;

    typedef enum int { K_R, K_LW, K_SW, K_BEQ, K_J, K_I, K_ILL } kind_e;
    typedef int path_q_t[$];

    logic [5:0] legal_ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                  6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

    function automatic kind_e classify(input logic [5:0] op);
        case (op)
            6'b000000: return K_R;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b001000, 6'b001100, 6'b001101, 6'b001010: return K_I;
            default:   return K_ILL;
        endcase
    endfunction

    // States visited by one instruction, FETCH first, ignoring memory stalls.
    function automatic path_q_t path_of(input logic [5:0] op);
        case (classify(op))
            K_LW:    return '{0, 1, 2, 3, 4};
            K_SW:    return '{0, 1, 2, 5};
            K_R:     return '{0, 1, 6, 7};
            K_BEQ:   return '{0, 1, 8};
            K_J:     return '{0, 1, 9};
            K_I:     return '{0, 1, 10, 11};
            default: return '{0, 1};
        endcase
    endfunction

    function automatic int cpi_of(input logic [5:0] op);
        case (classify(op))
            K_LW:           return 5;
            K_SW, K_R, K_I: return 4;
            K_BEQ, K_J:     return 3;
            default:        return 2;
        endcase
    endfunction

    // Expected outputs in a state; m marks fields with a defined value there (strobes always).
    function automatic void expect_of(input int st, input logic [5:0] op, input logic mr,
                                      output ob_t v, output ob_t m);
        v = '0;
        m = '0;
        {m.pcw, m.pcwc, m.mrd, m.mwr, m.irw, m.rw, m.ill} = 7'h7f;
        case (st)
            0: begin
                v.mrd = 1; v.irw = !WAIT_EN || mr; v.pcw = !WAIT_EN || mr;
                v.iord = 0; v.asa = 0; v.asb = 2'b01; v.aop = 2'b00; v.pcs = 2'b00;
                m.iord = 1; m.asa = 1; m.asb = 2'b11; m.aop = 2'b11; m.pcs = 2'b11;
            end
            1: begin
                v.asa = 0; v.asb = 2'b11; v.aop = 2'b00; v.ill = (classify(op) == K_ILL);
                m.asa = 1; m.asb = 2'b11; m.aop = 2'b11;
            end
            2: begin
                v.asa = 1; v.asb = 2'b10; v.aop = 2'b00;
                m.asa = 1; m.asb = 2'b11; m.aop = 2'b11;
            end
            3: begin v.mrd = 1; v.iord = 1; m.iord = 1; end
            4: begin v.rw = 1; v.m2r = 1; v.rdst = 0; m.m2r = 1; m.rdst = 1; end
            5: begin v.mwr = 1; v.iord = 1; m.iord = 1; end
            6: begin
                v.asa = 1; v.asb = 2'b00; v.aop = 2'b10;
                m.asa = 1; m.asb = 2'b11; m.aop = 2'b11;
            end
            7: begin v.rw = 1; v.rdst = 1; v.m2r = 0; m.m2r = 1; m.rdst = 1; end
            8: begin
                v.asa = 1; v.asb = 2'b00; v.aop = 2'b01; v.pcwc = 1; v.pcs = 2'b01;
                m.asa = 1; m.asb = 2'b11; m.aop = 2'b11; m.pcs = 2'b11;
            end
            9: begin v.pcw = 1; v.pcs = 2'b10; m.pcs = 2'b11; end
            10: begin
                v.asa = 1; v.asb = 2'b10; v.aop = 2'b11;
                m.asa = 1; m.asb = 2'b11; m.aop = 2'b11;
            end
            11: begin v.rw = 1; v.rdst = 0; v.m2r = 0; m.m2r = 1; m.rdst = 1; end
            default: ;
        endcase
    endfunction

    function automatic ob_t observe();
        ob_t o;
        o.pcw = PCWrite; o.pcwc = PCWriteCond; o.mrd = MemRead; o.mwr = MemWrite;
        o.irw = IRWrite; o.rw = RegWrite; o.ill = illegal_op; o.pcs = PCSource;
        o.iord = IorD; o.rdst = RegDst; o.m2r = MemtoReg; o.asa = ALUSrcA;
        o.asb = ALUSrcB; o.aop = ALUOp;
        return o;
    endfunction

    // Runs one instruction from FETCH; entered and left at posedge+1.
    task automatic run_instr(input logic [5:0] op, input bit rand_ready, output int cycles);
        path_q_t path;
        int      idx;
        bit      hold;
        ob_t     v, m, o;
        path   = path_of(op);
        opcode = op;
        idx    = 0;
        cycles = 0;
        while (idx < path.size() && cycles < 64) begin
            mem_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            n_vec++;
            if (state_dbg !== 4'(path[idx])) begin
                n_err++;
                $display("FAIL state op=%b cyc=%0d got=%0d want=%0d", op, cycles, state_dbg, path[idx]);
            end
            expect_of(path[idx], op, mem_ready, v, m);
            o = observe();
            n_vec++;
            if (((o ^ v) & m) !== 17'b0) begin
                n_err++;
                $display("FAIL outputs op=%b st=%0d rdy=%b got=%h want=%h mask=%h",
                         op, path[idx], mem_ready, o, v, m);
            end
            hold = WAIT_EN && !mem_ready && (path[idx] == 0 || path[idx] == 3 || path[idx] == 5);
            @(posedge clk);
            #1;
            cycles++;
            if (!hold) idx++;
        end
        if (idx < path.size()) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout op=%b got=%0d cycles want=%0d states", op, cycles, path.size());
        end
    endtask

    task automatic test_reset();
        ob_t v, m, o;
        rst = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
        #3;
        n_vec++;
        if (state_dbg !== 4'd0 || {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_init got st=%0d strobes=%b want st=0 strobes=0", state_dbg,
                     {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Walk an LW into MRD, then hit it with an asynchronous reset mid-cycle.
        opcode = 6'b100011;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (state_dbg !== 4'd3) begin
            n_err++;
            $display("FAIL reach_mrd got=%0d want=3", state_dbg);
        end
        #2 rst = 1'b1;
        #1;
        expect_of(0, opcode, 1'b1, v, m);
        {v.pcw, v.pcwc, v.mrd, v.mwr, v.irw, v.rw, v.ill} = 7'b0;
        o = observe();
        n_vec++;
        if (state_dbg !== 4'd0 || ((o ^ v) & m) !== 17'b0) begin
            n_err++;
            $display("FAIL reset_mid_mrd got st=%0d out=%h want st=0 out=%h", state_dbg, o, v);
        end
        @(posedge clk);
        #1;
        o = observe();
        n_vec++;
        if (state_dbg !== 4'd0 || ((o ^ v) & m) !== 17'b0) begin
            n_err++;
            $display("FAIL reset_held got st=%0d out=%h want st=0 out=%h", state_dbg, o, v);
        end
        #3 rst = 1'b0;
        #1;
        expect_of(0, opcode, 1'b1, v, m);
        o = observe();
        n_vec++;
        if (state_dbg !== 4'd0 || ((o ^ v) & m) !== 17'b0) begin
            n_err++;
            $display("FAIL post_reset_fetch got st=%0d out=%h want st=0 out=%h", state_dbg, o, v);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (state_dbg !== 4'd1) begin
            n_err++;
            $display("FAIL post_reset_decode got=%0d want=1", state_dbg);
        end
        // Finish the LW so the next test starts in FETCH.
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [5:0] ops [5] = '{6'b100011, 6'b000100, 6'b000010, 6'b111111, 6'b101011};
        int cyc;
        foreach (ops[i]) begin
            run_instr(ops[i], 1'b0, cyc);
            n_vec++;
            if (cyc !== cpi_of(ops[i])) begin
                n_err++;
                $display("FAIL cpi op=%b got=%0d want=%0d", ops[i], cyc, cpi_of(ops[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [5:0] op;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 9) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 8)];
            run_instr(op, 1'b1, cyc);
            if (!WAIT_EN) begin
                n_vec++;
                if (cyc !== cpi_of(op)) begin
                    n_err++;
                    $display("FAIL cpi_rand op=%b got=%0d want=%0d", op, cyc, cpi_of(op));
                end
            end
        end
        #1;
        n_vec++;
        if (state_dbg !== 4'd0) begin
            n_err++;
            $display("FAIL final_state got=%0d want=0", state_dbg);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef MC_CTRL_MEM_WAIT_EN
    task automatic test_mem_wait();
        int n;
        opcode = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            n_vec++;
            if (state_dbg !== 4'd0 || MemRead !== 1'b1 || PCWrite !== (i == 3) || IRWrite !== (i == 3)) begin
                n_err++;
                $display("FAIL fetch_wait i=%0d got st=%0d mr=%b pcw=%b irw=%b want st=0 mr=1 pcw=irw=%0d",
                         i, state_dbg, MemRead, PCWrite, IRWrite, (i == 3));
            end
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (state_dbg !== 4'd1) begin
            n_err++;
            $display("FAIL fetch_wait_exit got=%0d want=1", state_dbg);
        end
        mem_ready = 1'b1;
        n = 0;
        while (state_dbg !== 4'd0 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_vec++;
        if (n !== 4) begin
            n_err++;
            $display("FAIL fetch_wait_finish got=%0d cycles want=4", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
`ifdef MC_CTRL_MEM_WAIT_EN
        test_mem_wait();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
